// File: rtl/lti_biquad_tdm.sv
// Time-shared multi-channel DF-II-T biquad with one multiplier and sample-strobe framing.
// Define LTI_SAT_EN to saturate internal sums and sig_out instead of wrapping.
module lti_biquad_tdm #(
    parameter int NCH = 2,
    parameter int IW  = 16,
    parameter int OW  = 20,
    parameter int SW  = 24,
    parameter int CW  = 18,
    parameter int CF  = 16,
    parameter int B0  = 65536,
    parameter int B1  = 0,
    parameter int B2  = 0,
    parameter int A1  = 0,
    parameter int A2  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_in,
    input  logic [NCH*IW-1:0] sig_in,
    output logic              ce_out,
    output logic [NCH*OW-1:0] sig_out,
    output logic              busy,
    output logic              overrun
);
    localparam int PW  = CW + SW;
    localparam int XW  = PW + 2;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic signed [CW-1:0] CB0 = CW'(B0);
    localparam logic signed [CW-1:0] CB1 = CW'(B1);
    localparam logic signed [CW-1:0] CB2 = CW'(B2);
    localparam logic signed [CW-1:0] CA1 = CW'(A1);
    localparam logic signed [CW-1:0] CA2 = CW'(A2);

    typedef enum logic [2:0] {IDLE, MB0, MB1, MB2, MA1, MA2, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CHW-1:0]           ch_q, ch_d;
    logic [NCH*IW-1:0]        x_q, x_d;
    logic signed [SW-1:0]     y_q, y_d;
    logic signed [SW-1:0]     s1n_q, s1n_d;
    logic signed [PW-1:0]     acc1_q, acc1_d;
    logic signed [PW-1:0]     acc2_q, acc2_d;
    logic [NCH*OW-1:0]        stage_q, stage_d;
    logic [NCH*OW-1:0]        out_q, out_d;
    logic                     ce_q, ce_d;
    logic                     busy_q, busy_d;
    logic                     ovr_q, ovr_d;
    logic signed [SW-1:0]     s1_q [NCH];
    logic signed [SW-1:0]     s2_q [NCH];

    logic signed [IW-1:0]     xi;
    logic signed [SW-1:0]     xs;
    logic signed [CW-1:0]     coef;
    logic signed [SW-1:0]     data;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     psh;
    logic signed [SW-1:0]     s2n;
    logic                     wr;

    function automatic logic signed [SW-1:0] fit_sw(input logic signed [XW-1:0] v);
`ifdef LTI_SAT_EN
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        hi = {{(XW-SW+1){1'b0}}, {(SW-1){1'b1}}};
        lo = {{(XW-SW+1){1'b1}}, {(SW-1){1'b0}}};
        if (v > hi)      fit_sw = hi[SW-1:0];
        else if (v < lo) fit_sw = lo[SW-1:0];
        else             fit_sw = v[SW-1:0];
`else
        fit_sw = v[SW-1:0];
`endif
    endfunction

    function automatic logic [OW-1:0] fit_ow(input logic signed [SW-1:0] v);
`ifdef LTI_SAT_EN
        logic signed [SW:0] hi;
        logic signed [SW:0] lo;
        hi = {{(SW-OW+2){1'b0}}, {(OW-1){1'b1}}};
        lo = {{(SW-OW+2){1'b1}}, {(OW-1){1'b0}}};
        if (SW'(v) > hi)      fit_ow = hi[OW-1:0];
        else if (SW'(v) < lo) fit_ow = lo[OW-1:0];
        else                  fit_ow = v[OW-1:0];
`else
        fit_ow = v[OW-1:0];
`endif
    endfunction

    // Single shared multiplier: operands selected by the current phase.
    always_comb begin
        xi   = x_q[ch_q*IW +: IW];
        xs   = SW'(xi);
        coef = '0;
        data = '0;
        unique case (state_q)
            MB0:     begin coef = CB0; data = xs;  end
            MB1:     begin coef = CB1; data = xs;  end
            MB2:     begin coef = CB2; data = xs;  end
            MA1:     begin coef = CA1; data = y_q; end
            MA2:     begin coef = CA2; data = y_q; end
            default: begin coef = '0;  data = '0;  end
        endcase
        prod = PW'(coef) * PW'(data);
        psh  = prod >>> CF;
        s2n  = fit_sw(XW'(acc2_q) - XW'(psh));
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        x_d     = x_q;
        y_d     = y_q;
        s1n_d   = s1n_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        stage_d = stage_q;
        out_d   = out_q;
        ce_d    = 1'b0;
        busy_d  = busy_q;
        ovr_d   = ovr_q | (ce_in && state_q != IDLE);
        wr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ce_in) begin
                    x_d     = sig_in;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = MB0;
                end
            end
            MB0: begin
                y_d     = fit_sw(XW'(psh) + XW'(s1_q[ch_q]));
                state_d = MB1;
            end
            MB1: begin
                acc1_d  = psh;
                state_d = MB2;
            end
            MB2: begin
                acc2_d  = psh;
                state_d = MA1;
            end
            MA1: begin
                s1n_d   = fit_sw(XW'(acc1_q) - XW'(psh) + XW'(s2_q[ch_q]));
                state_d = MA2;
            end
            MA2: begin
                wr = 1'b1;
                stage_d[ch_q*OW +: OW] = fit_ow(y_q);
                if (ch_q == CHW'(NCH - 1)) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = MB0;
                end
            end
            DONE: begin
                out_d   = stage_q;
                ce_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            s1n_q   <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            stage_q <= '0;
            out_q   <= '0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s1n_q   <= s1n_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            if (wr) begin
                s1_q[ch_q] <= s1n_q;
                s2_q[ch_q] <= s2n;
            end
        end
    end

    assign ce_out  = ce_q;
    assign sig_out = out_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;
endmodule

// File: tb/tb_lti_biquad_tdm.sv
// Directed scoreboard bench: identity, pure delay, feedback and saturation instances share framing.
module tb_lti_biquad_tdm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce_in = 1'b0;
    logic [31:0] si0 = '0, si1 = '0, si2 = '0, si3 = '0;
    logic [39:0] so0, so1, so2;
    logic [31:0] so3;
    logic ce0, ce1, ce2, ce3;
    logic bz0, bz1, bz2, bz3;
    logic ov0, ov1, ov2, ov3;

    int n_tests = 0;
    int n_fail = 0;
    int ce_seen = 0;

    typedef struct packed {
        logic [39:0] e0;
        logic [39:0] e1;
        logic [39:0] e2;
        logic [31:0] e3;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    lti_biquad_tdm u0 (
        .clk(clk), .reset(reset), .ce_in(ce_in), .sig_in(si0),
        .ce_out(ce0), .sig_out(so0), .busy(bz0), .overrun(ov0));
    lti_biquad_tdm #(.B0(0), .B1(65536)) u1 (
        .clk(clk), .reset(reset), .ce_in(ce_in), .sig_in(si1),
        .ce_out(ce1), .sig_out(so1), .busy(bz1), .overrun(ov1));
    lti_biquad_tdm #(.A1(-32768)) u2 (
        .clk(clk), .reset(reset), .ce_in(ce_in), .sig_in(si2),
        .ce_out(ce2), .sig_out(so2), .busy(bz2), .overrun(ov2));
    lti_biquad_tdm #(.OW(16), .SW(16), .B0(98304)) u3 (
        .clk(clk), .reset(reset), .ce_in(ce_in), .sig_in(si3),
        .ce_out(ce3), .sig_out(so3), .busy(bz3), .overrun(ov3));

`ifdef LTI_SAT_EN
    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;
`else
    localparam logic [15:0] SAT_POS = 16'hBFFE;
    localparam logic [15:0] SAT_NEG = 16'h4000;
`endif

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [39:0] a, input logic [39:0] b,
                        input logic [39:0] c, input logic [31:0] d);
        exp_t e;
        e.e0 = a;
        e.e1 = b;
        e.e2 = c;
        e.e3 = d;
        q.push_back(e);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        si0 = a;
        si1 = b;
        si2 = c;
        si3 = d;
        ce_in = 1'b1;
        @(negedge clk);
        ce_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ce0) begin
            exp_t e;
            ce_seen++;
            n_tests++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_ce_out got 1 want 0");
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ce_all", {37'd0, ce1, ce2, ce3}, 40'd7);
                chk("out_ident", so0, e.e0);
                chk("out_delay", so1, e.e1);
                chk("out_fback", so2, e.e2);
                chk("out_sat", {8'd0, so3}, {8'd0, e.e3});
            end
        end
    end

    initial begin
        int lat;
        int bcnt;
        bit got;
        repeat (3) @(negedge clk);
        chk("rst_sig_out", so0, 40'd0);
        chk("rst_flags", {36'd0, ce0, bz0, ov0, 1'b0}, 40'd0);
        reset = 1'b0;
        @(negedge clk);

        // Frame 1: latency and busy width
        push({20'hFC000, 20'h04000}, 40'd0, {20'h0, 20'h01000}, {16'h0, SAT_POS});
        si0 = {16'hC000, 16'h4000};
        si1 = {16'h0, 16'h4000};
        si2 = {16'h0, 16'h1000};
        si3 = {16'h0, 16'h7FFF};
        ce_in = 1'b1;
        lat = 0;
        bcnt = 0;
        got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            ce_in = 1'b0;
            if (bz0) bcnt++;
            if (ce0) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk("latency", 40'(lat), 40'd12);
        chk("busy_cycles", 40'(bcnt), 40'd11);

        // Frames 2,3 at minimum frame period
        push({20'hF8000, 20'h07FFF}, {20'h0, 20'h04000}, {20'h0, 20'h00800},
             {SAT_NEG, 16'h0});
        start({16'h8000, 16'h7FFF}, {16'h0, 16'h4000}, 32'h0, {16'h8000, 16'h0});
        repeat (11) @(negedge clk);
        push({20'hFFFFF, 20'h00001}, {20'h0, 20'h04000}, {20'h0, 20'h00400},
             {16'h0, 16'h1800});
        start({16'hFFFF, 16'h0001}, {16'h0, 16'h4000}, 32'h0, {16'h0, 16'h1000});
        repeat (20) @(negedge clk);
        chk("hold_sig_out", so0, {20'hFFFFF, 20'h00001});
        chk("no_overrun", {39'd0, ov0}, 40'd0);
        chk("frames_3", 40'(ce_seen), 40'd3);

        // Frame 4 with a dropped second strobe
        push({20'h0, 20'h01234}, {20'h0, 20'h04000}, {20'h0, 20'h00200}, 32'h0);
        start({16'h0, 16'h1234}, {16'h0, 16'h4000}, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        start({16'h5555, 16'h5555}, {16'h0, 16'h7000}, {16'h0, 16'h1000}, 32'h7FFF7FFF);
        chk("overrun_set", {39'd0, ov0}, 40'd1);
        repeat (14) @(negedge clk);
        chk("overrun_sticky", {39'd0, ov0}, 40'd1);
        chk("frames_4", 40'(ce_seen), 40'd4);
        chk("queue_drained", 40'(q.size()), 40'd0);

        // Reset mid-frame
        start({16'h1111, 16'h2222}, {16'h0, 16'h4000}, {16'h0, 16'h1000}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_no_ce", 40'(ce_seen), 40'd4);
        chk("abort_sig_out", so0, 40'd0);
        chk("abort_flags", {38'd0, bz0, ov0}, 40'd0);

        // Same as first frame after power-up
        push({20'hFC000, 20'h04000}, 40'd0, {20'h0, 20'h01000}, {16'h0, SAT_POS});
        start({16'hC000, 16'h4000}, {16'h0, 16'h4000}, {16'h0, 16'h1000},
              {16'h0, 16'h7FFF});
        repeat (14) @(negedge clk);
        chk("frames_5", 40'(ce_seen), 40'd5);
        chk("final_drained", 40'(q.size()), 40'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
